// File: rtl/instr_loader_pkg.sv
// Shared constants, FSM state type and reset program image for the instruction loader.
package instr_loader_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reset image; index 0 is the rightmost entry.
  localparam logic [DEPTH-1:0][DATA_W-1:0] DEFAULT_PROGRAM = {
    8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12,
    8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01
  };

endpackage

// File: rtl/instr_ram.sv
// 16x8 instruction store: reset image, synchronous write, combinational read.
module instr_ram
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Storage array; reset restores the default program.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= DEFAULT_PROGRAM;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_loader.sv
// Writable instruction store with a byte-load front end that holds the CPU in reset while loading.
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [CNT_W-1:0]  byte_count
);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              xfer;
  logic              last;

  // byte_ready is a registered copy of (state == LOAD), so no path from byte_valid.
  assign xfer = byte_valid & byte_ready;
  assign last = (wr_ptr == ADDR_W'(DEPTH - 1));

  // Load-control FSM with registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      wr_ptr     <= '0;
      byte_count <= '0;
      load_done  <= 1'b0;
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        RUN: begin
          if (load_req) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            byte_count <= '0;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            byte_count <= byte_count + CNT_W'(1);
            // Pointer saturates at the last entry; a full load always ends here.
            if (!last) begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
          end
          if ((xfer && last) || !load_req) begin
            state      <= DONE;
            byte_ready <= 1'b0;
            load_done  <= 1'b1;
          end
        end
        DONE: begin
          if (!load_req) begin
            state    <= RUN;
            cpu_hold <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

  instr_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (xfer),
    .waddr (wr_ptr),
    .wdata (byte_in),
    .raddr (fetch_addr),
    .rdata (instruction)
  );

endmodule
